// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU batch-run controller.
//   state_e      : controller states
//   ERR_*        : bit positions within the sticky error vector
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int unsigned ERR_WIDTH    = 2;
    localparam int unsigned ERR_TIMEOUT  = 0;
    localparam int unsigned ERR_OVERFLOW = 1;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   flush        : empties the FIFO, overrides push/pop
//   push, wdata  : write request and data (accepted when not full, or full with pop)
//   pop          : consume head (ignored when empty)
//   full, empty  : occupancy flags
//   rdata        : current head entry
module result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    // Pointer and occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Batch-run sequencer around the vector CPU: preloads data memory from the
// host, releases the CPU, captures flagged outputs, stops on output count or
// timeout, then drains results to the host.
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   start, abort               : run control (abort has top priority)
//   cfg_num_outputs/cfg_timeout: run configuration, latched on start
//   load_*                     : host preload stream (valid/ready)
//   mem_sel/we/addr/wdata      : data-memory port mux control and preload write
//   cpu_reset, cpu_out(_flag)  : CPU reset and output capture
//   res_valid/ready/data       : result stream to host (FWFT FIFO head)
//   busy, done, error, cycle_count : status
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned VECTOR_SIZE     = 6,
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned CYCLE_WIDTH     = 32,
    parameter int unsigned OUT_COUNT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [OUT_COUNT_WIDTH-1:0] cfg_num_outputs,
    input  logic [CYCLE_WIDTH-1:0]     cfg_timeout,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [ADDR_WIDTH-1:0]      load_addr,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] load_data,
    input  logic                       load_last,
    output logic                       mem_sel,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] mem_wdata,
    output logic                       cpu_reset,
    input  logic [DATA_WIDTH*VECTOR_SIZE-1:0] cpu_out,
    input  logic                       cpu_out_flag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [DATA_WIDTH*VECTOR_SIZE-1:0] res_data,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 error,
    output logic [CYCLE_WIDTH-1:0]     cycle_count
);

    localparam int unsigned VW = DATA_WIDTH * VECTOR_SIZE;

    state_e                      state_q, state_d;
    logic [OUT_COUNT_WIDTH-1:0]  cfg_num_q, cfg_num_d;
    logic [CYCLE_WIDTH-1:0]      cfg_timeout_q, cfg_timeout_d;
    logic [OUT_COUNT_WIDTH-1:0]  out_count_q, out_count_d;
    logic [CYCLE_WIDTH-1:0]      cycle_count_q, cycle_count_d;
    logic [ERR_WIDTH-1:0]        error_q, error_d;
    logic                        last_seen_q, last_seen_d;
    logic                        load_ready_q, load_ready_d;
    logic                        mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
    logic [VW-1:0]               mem_wdata_q, mem_wdata_d;
    logic                        cpu_reset_q, cpu_reset_d;
    logic                        mem_sel_q, mem_sel_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic                        load_hs;
    logic [CYCLE_WIDTH:0]        cycle_inc;
    logic                        fifo_push, fifo_pop, fifo_flush;
    logic                        fifo_full, fifo_empty;

    assign load_hs   = (state_q == LOAD) && load_valid && load_ready_q;
    assign cycle_inc = {1'b0, cycle_count_q} + (CYCLE_WIDTH+1)'(1);
    assign fifo_push = (state_q == RUN) && cpu_out_flag;
    assign fifo_pop  = !fifo_empty && res_ready &&
                       ((state_q == RUN) || (state_q == DRAIN) || (state_q == DONE));
    assign fifo_flush = abort;

    result_fifo #(
        .WIDTH (VW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clock (clock),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .wdata (cpu_out),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .rdata (res_data)
    );

    // Next-state, counters and preload write path.
    always_comb begin
        state_d       = state_q;
        cfg_num_d     = cfg_num_q;
        cfg_timeout_d = cfg_timeout_q;
        out_count_d   = out_count_q;
        cycle_count_d = cycle_count_q;
        error_d       = error_q;
        last_seen_d   = last_seen_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = LOAD;
                    cfg_num_d     = cfg_num_outputs;
                    cfg_timeout_d = cfg_timeout;
                    out_count_d   = '0;
                    cycle_count_d = '0;
                    error_d       = '0;
                    last_seen_d   = 1'b0;
                end
            end
            LOAD: begin
                if (load_hs) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = load_addr;
                    mem_wdata_d = load_data;
                    if (load_last) last_seen_d = 1'b1;
                end
                // One extra LOAD cycle lets the final write issue before the CPU runs.
                if (last_seen_q) state_d = RUN;
            end
            RUN: begin
                cycle_count_d = cycle_inc[CYCLE_WIDTH] ? cycle_count_q
                                                       : cycle_inc[CYCLE_WIDTH-1:0];
                out_count_d   = out_count_q + OUT_COUNT_WIDTH'(cpu_out_flag);
                if (fifo_push && fifo_full && !fifo_pop) error_d[ERR_OVERFLOW] = 1'b1;
                // Reaching the output count takes precedence over a coincident timeout.
                if (out_count_d >= cfg_num_q) begin
                    state_d = DRAIN;
                end else if (cycle_inc == {1'b0, cfg_timeout_q}) begin
                    error_d[ERR_TIMEOUT] = 1'b1;
                    state_d              = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d       = IDLE;
            out_count_d   = '0;
            cycle_count_d = '0;
            error_d       = '0;
            last_seen_d   = 1'b0;
            mem_we_d      = 1'b0;
        end
    end

    // Status outputs follow the state being entered so they line up with it.
    always_comb begin
        load_ready_d = (state_d == LOAD) && !last_seen_d;
        cpu_reset_d  = (state_d != RUN);
        mem_sel_d    = (state_d != RUN);
        busy_d       = (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cfg_num_q     <= '0;
            cfg_timeout_q <= '0;
            out_count_q   <= '0;
            cycle_count_q <= '0;
            error_q       <= '0;
            last_seen_q   <= 1'b0;
            load_ready_q  <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_reset_q   <= 1'b1;
            mem_sel_q     <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_num_q     <= cfg_num_d;
            cfg_timeout_q <= cfg_timeout_d;
            out_count_q   <= out_count_d;
            cycle_count_q <= cycle_count_d;
            error_q       <= error_d;
            last_seen_q   <= last_seen_d;
            load_ready_q  <= load_ready_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_reset_q   <= cpu_reset_d;
            mem_sel_q     <= mem_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign load_ready  = load_ready_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_reset   = cpu_reset_q;
    assign mem_sel     = mem_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cycle_count = cycle_count_q;
    assign res_valid   = !fifo_empty;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: preload, normal run, timeout,
// overflow, output/timeout tie, zero-output run and abort.
module tb_cpu_run_controller;

    localparam int unsigned DW  = 16;
    localparam int unsigned VS  = 6;
    localparam int unsigned VW  = DW * VS;
    localparam int unsigned AW  = 16;
    localparam int unsigned CYW = 32;
    localparam int unsigned OCW = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           abort;
    logic [OCW-1:0] cfg_num_outputs;
    logic [CYW-1:0] cfg_timeout;
    logic           load_valid;
    logic           load_ready;
    logic [AW-1:0]  load_addr;
    logic [VW-1:0]  load_data;
    logic           load_last;
    logic           mem_sel;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [VW-1:0]  mem_wdata;
    logic           cpu_reset;
    logic [VW-1:0]  cpu_out;
    logic           cpu_out_flag;
    logic           res_valid;
    logic           res_ready;
    logic [VW-1:0]  res_data;
    logic           busy;
    logic           done;
    logic [1:0]     error;
    logic [CYW-1:0] cycle_count;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [63:0]    flag_mask;
    logic [VW-1:0]  exp_q[$];
    int             len;

    always #5 clock = ~clock;

    cpu_run_controller dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cfg_num_outputs (cfg_num_outputs),
        .cfg_timeout     (cfg_timeout),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_addr       (load_addr),
        .load_data       (load_data),
        .load_last       (load_last),
        .mem_sel         (mem_sel),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .cpu_reset       (cpu_reset),
        .cpu_out         (cpu_out),
        .cpu_out_flag    (cpu_out_flag),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .cycle_count     (cycle_count)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] vec(input int k);
        return {16'hC0DE, 16'(k), 16'hBEEF, 16'(k * 3), 16'h1234, 16'(k + 7)};
    endfunction

    // Drives one RUN cycle per iteration from the current negedge; scoreboards pops.
    task automatic drive_run(input int max_cyc, output int run_len);
        run_len = max_cyc + 1;
        for (int k = 1; k <= max_cyc; k++) begin
            cpu_out_flag = flag_mask[k];
            cpu_out      = vec(k);
            if (res_valid && res_ready) begin
                check_eq("res_pending", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) check_eq("res_data", 128'(res_data), 128'(exp_q.pop_front()));
            end
            @(negedge clock);
            if (done) begin
                run_len = k;
                break;
            end
        end
        cpu_out_flag = 1'b0;
    endtask

    // Start a run with a single preload word; returns at the negedge of RUN cycle 1.
    task automatic start_and_load(input int num, input int tmo);
        cfg_num_outputs = OCW'(num);
        cfg_timeout     = CYW'(tmo);
        start           = 1'b1;
        @(negedge clock);
        start      = 1'b0;
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_addr  = 16'h0000;
        load_data  = vec(200);
        @(negedge clock);
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_num_outputs = '0; cfg_timeout = '0;
        load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
        cpu_out = '0; cpu_out_flag = 1'b0; res_ready = 1'b0;
        flag_mask = '0;
        repeat (3) @(negedge clock);

        check_eq("rst_cpu_reset", 128'(cpu_reset), 128'(1));
        check_eq("rst_mem_sel",   128'(mem_sel),   128'(1));
        check_eq("rst_ctrl", 128'({load_ready, mem_we, res_valid, busy, done}), 128'(0));
        check_eq("rst_error",     128'(error),       128'(0));
        check_eq("rst_cycles",    128'(cycle_count), 128'(0));
        check_eq("rst_mem_addr",  128'(mem_addr),    128'(0));

        reset = 1'b0;
        @(negedge clock);

        // Three-word preload, last on the third.
        cfg_num_outputs = 8'd2;
        cfg_timeout     = 32'd1000;
        start           = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check_eq("load_ready_on", 128'(load_ready), 128'(1));
        check_eq("load_busy",     128'(busy),       128'(1));
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_addr  = AW'(16'h10 + i);
            load_data  = vec(100 + i);
            load_last  = (i == 2);
            @(negedge clock);
            check_eq("pre_we",    128'(mem_we),    128'(1));
            check_eq("pre_addr",  128'(mem_addr),  128'(16'h10 + i));
            check_eq("pre_wdata", 128'(mem_wdata), 128'(vec(100 + i)));
            check_eq("pre_cpu_rst", 128'(cpu_reset), 128'(1));
        end
        check_eq("load_ready_off", 128'(load_ready), 128'(0));
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clock);
        check_eq("run_cpu_reset", 128'(cpu_reset), 128'(0));
        check_eq("run_mem_sel",   128'(mem_sel),   128'(0));
        check_eq("run_we_idle",   128'(mem_we),    128'(0));

        // Two outputs at RUN cycles 5 and 9.
        flag_mask = '0; flag_mask[5] = 1'b1; flag_mask[9] = 1'b1;
        exp_q = {vec(5), vec(9)};
        res_ready = 1'b1;
        drive_run(40, len);
        check_eq("norm_len",    128'(len),         128'(11));
        check_eq("norm_cycles", 128'(cycle_count), 128'(9));
        check_eq("norm_error",  128'(error),       128'(0));
        check_eq("norm_left",   128'(exp_q.size()), 128'(0));
        check_eq("norm_cpu_rst", 128'(cpu_reset),  128'(1));

        // Timeout after 20 RUN cycles, no flags.
        flag_mask = '0;
        start_and_load(3, 20);
        drive_run(40, len);
        check_eq("tmo_len",    128'(len),         128'(21));
        check_eq("tmo_error",  128'(error),       128'(1));
        check_eq("tmo_cycles", 128'(cycle_count), 128'(20));
        check_eq("tmo_done",   128'(done),        128'(1));

        // Overflow: six back-to-back flags with no consumer.
        res_ready = 1'b0;
        flag_mask = '0;
        for (int i = 1; i <= 6; i++) flag_mask[i] = 1'b1;
        start_and_load(6, 1000);
        drive_run(8, len);
        check_eq("ovf_not_done", 128'(len),       128'(9));
        check_eq("ovf_error",    128'(error),     128'(2));
        check_eq("ovf_busy",     128'(busy),      128'(1));
        check_eq("ovf_head",     128'(res_data),  128'(vec(1)));
        flag_mask = '0;
        exp_q = {vec(1), vec(2), vec(3), vec(4)};
        res_ready = 1'b1;
        drive_run(20, len);
        check_eq("ovf_drain_len", 128'(len),          128'(5));
        check_eq("ovf_left",      128'(exp_q.size()), 128'(0));
        check_eq("ovf_error_hold", 128'(error),       128'(2));
        check_eq("ovf_cycles",    128'(cycle_count),  128'(6));

        // Final output coincides with timeout expiry.
        flag_mask = '0; flag_mask[4] = 1'b1;
        exp_q = {vec(4)};
        start_and_load(1, 4);
        drive_run(20, len);
        check_eq("tie_len",    128'(len),          128'(6));
        check_eq("tie_error",  128'(error),        128'(0));
        check_eq("tie_cycles", 128'(cycle_count),  128'(4));
        check_eq("tie_left",   128'(exp_q.size()), 128'(0));

        // Zero outputs requested: single RUN cycle.
        flag_mask = '0;
        start_and_load(0, 100);
        drive_run(20, len);
        check_eq("zero_len",    128'(len),         128'(2));
        check_eq("zero_cycles", 128'(cycle_count), 128'(1));
        check_eq("zero_error",  128'(error),       128'(0));

        // Abort in RUN with two results queued.
        res_ready = 1'b0;
        flag_mask = '0; flag_mask[1] = 1'b1; flag_mask[2] = 1'b1;
        start_and_load(5, 1000);
        drive_run(4, len);
        check_eq("abt_running", 128'(len),       128'(5));
        check_eq("abt_queued",  128'(res_valid), 128'(1));
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_eq("abt_res_valid", 128'(res_valid),   128'(0));
        check_eq("abt_cpu_reset", 128'(cpu_reset),   128'(1));
        check_eq("abt_error",     128'(error),       128'(0));
        check_eq("abt_cycles",    128'(cycle_count), 128'(0));
        check_eq("abt_idle", 128'({busy, done, mem_sel}), 128'(3'b001));

        // Clean run after abort.
        exp_q.delete();
        flag_mask = '0; flag_mask[3] = 1'b1;
        exp_q = {vec(3)};
        res_ready = 1'b1;
        start_and_load(1, 100);
        drive_run(20, len);
        check_eq("post_len",    128'(len),          128'(5));
        check_eq("post_cycles", 128'(cycle_count),  128'(3));
        check_eq("post_error",  128'(error),        128'(0));
        check_eq("post_left",   128'(exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
